// File: rtl/store_buffer.sv
// Four-entry in-order store buffer sitting between the MEM stage and data memory.
// Latency 2 cycles push-to-DM-write; loads take the DM port first, and st_ready drops when full or flushing.
module store_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [3:0]  st_be,
    input  logic [31:0] st_pc,
    output logic        st_ready,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    output logic        ld_stall,
    input  logic        flush,
    output logic        flush_done,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_data,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_pc,
    output logic [2:0]  count
);
    typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

    state_t      state;
    logic [31:0] addr_q [4];
    logic [31:0] data_q [4];
    logic [31:0] pc_q   [4];
    logic [3:0]  be_q   [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [3:0]  entry_vld;
    logic        hit;
    logic        push;
    logic        pop;

    assign st_ready = (count != 3'd4) && (state != FLUSH);
    assign push     = st_valid && st_ready;
    // A stalled load still lets the buffer drain, otherwise the stall could never clear.
    assign pop      = (count != 3'd0) && (!ld_req || ld_stall || (state == FLUSH));
    assign ld_stall = ld_req && hit;

    always_comb begin
        hit = dm_we && (dm_addr[31:2] == ld_addr[31:2]);
        for (int i = 0; i < 4; i++) begin
            entry_vld[i] = ({1'b0, 2'(i) - rd_ptr} < count);
            if (entry_vld[i] && (addr_q[i][31:2] == ld_addr[31:2]))
                hit = 1'b1;
        end
    end

    // Payload storage needs no reset; validity comes from count and pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= st_addr;
            data_q[wr_ptr] <= st_data;
            be_q[wr_ptr]   <= st_be;
            pc_q[wr_ptr]   <= st_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
            count   <= 3'd0;
            dm_we   <= 1'b0;
            dm_addr <= 32'd0;
            dm_data <= 32'd0;
            dm_be   <= 4'd0;
            dm_pc   <= 32'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            dm_we <= pop;
            if (pop) begin
                dm_addr <= addr_q[rd_ptr];
                dm_data <= data_q[rd_ptr];
                dm_be   <= be_q[rd_ptr];
                dm_pc   <= pc_q[rd_ptr];
            end
        end
    end

    // flush_done is registered alongside the FLUSH->DONE transition so it is high only in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            flush_done <= 1'b0;
        end else begin
            flush_done <= (state == FLUSH) && (count == 3'd0) && !dm_we;
            case (state)
                RUN:     if (flush) state <= FLUSH;
                FLUSH:   if ((count == 3'd0) && !dm_we) state <= DONE;
                DONE:    state <= RUN;
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: single store, fill, hazard, flush, wrap and async reset.
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic [31:0] st_pc;
    logic        st_ready;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic        flush;
    logic        flush_done;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_data;
    logic [3:0]  dm_be;
    logic [31:0] dm_pc;
    logic [2:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    store_buffer dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be), .st_pc(st_pc),
        .st_ready(st_ready), .ld_req(ld_req), .ld_addr(ld_addr), .ld_stall(ld_stall),
        .flush(flush), .flush_done(flush_done),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_data(dm_data), .dm_be(dm_be), .dm_pc(dm_pc),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_entry(input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_be    = 4'hF;
        st_pc    = a + 32'h1000;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic expect_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] cnt);
        tick();
        check({tag, "_we"}, dm_we, 1'b1);
        check({tag, "_addr"}, dm_addr, a);
        check({tag, "_data"}, dm_data, d);
        check({tag, "_cnt"}, count, cnt);
    endtask

    initial begin
        reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0; st_pc = '0;
        ld_req = 1'b1; ld_addr = '0; flush = 1'b0;
        @(negedge clk);
        check("rst_count", count, 0);
        check("rst_ready", st_ready, 1);
        check("rst_we", dm_we, 0);
        check("rst_addr", dm_addr, 0);
        check("rst_done", flush_done, 0);
        check("rst_stall", ld_stall, 0);
        reset = 1'b0; ld_req = 1'b0;
        tick();

        // Single store: visible on dm_* one cycle after the push edge.
        st_valid = 1'b1; st_addr = 32'h10; st_data = 32'hDEADBEEF; st_be = 4'hF; st_pc = 32'h3000;
        tick();
        st_valid = 1'b0;
        check("single_cnt1", count, 1);
        check("single_we0", dm_we, 0);
        tick();
        check("single_we", dm_we, 1);
        check("single_addr", dm_addr, 32'h10);
        check("single_data", dm_data, 32'hDEADBEEF);
        check("single_be", dm_be, 4'hF);
        check("single_pc", dm_pc, 32'h3000);
        check("single_cnt0", count, 0);
        tick();
        check("single_we_off", dm_we, 0);
        check("single_addr_hold", dm_addr, 32'h10);

        // Fill with loads holding the port; fifth push is refused.
        ld_req = 1'b1; ld_addr = 32'h100;
        for (int k = 0; k < 5; k++) begin
            st_valid = 1'b1; st_addr = 32'h40 + 32'(4 * k); st_data = 32'hA0 + 32'(k); st_be = 4'hF;
            #1;
            check("fill_ready", st_ready, (k < 4) ? 1 : 0);
            check("fill_stall", ld_stall, 0);
            tick();
        end
        st_valid = 1'b0;
        check("fill_cnt4", count, 4);
        check("fill_ready_full", st_ready, 0);
        ld_req = 1'b0;
        for (int k = 0; k < 4; k++)
            expect_write("fill_wr", 32'h40 + 32'(4 * k), 32'hA0 + 32'(k), 3'(3 - k));
        tick();
        check("fill_idle", dm_we, 0);

        // Hazard: same word with different byte offset stalls, next word does not.
        ld_req = 1'b1; ld_addr = 32'h100;
        st_valid = 1'b1; st_addr = 32'h24; st_data = 32'h55; st_be = 4'h1;
        tick();
        st_valid = 1'b0;
        ld_addr = 32'h28;
        #1 check("haz_other_word", ld_stall, 0);
        tick();
        check("haz_held_cnt", count, 1);
        check("haz_other_word2", ld_stall, 0);
        ld_addr = 32'h27;
        #1 check("haz_same_word", ld_stall, 1);
        tick();
        check("haz_we", dm_we, 1);
        check("haz_addr", dm_addr, 32'h24);
        check("haz_cnt0", count, 0);
        check("haz_dm_match", ld_stall, 1);
        tick();
        check("haz_we_off", dm_we, 0);
        check("haz_clear", ld_stall, 0);

        // Flush with 3 queued entries; loads do not block the drain.
        ld_addr = 32'h100;
        push_entry(32'h60, 32'hC0);
        push_entry(32'h64, 32'hC1);
        push_entry(32'h68, 32'hC2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_ready", st_ready, 0);
        check("flush_cnt3", count, 3);
        check("flush_we0", dm_we, 0);
        expect_write("flush_wr0", 32'h60, 32'hC0, 2);
        expect_write("flush_wr1", 32'h64, 32'hC1, 1);
        expect_write("flush_wr2", 32'h68, 32'hC2, 0);
        check("flush_ready_drain", st_ready, 0);
        tick();
        check("flush_we_off", dm_we, 0);
        check("flush_done_early", flush_done, 0);
        tick();
        check("flush_done", flush_done, 1);
        check("flush_done_ready", st_ready, 1);
        tick();
        check("flush_done_pulse", flush_done, 0);
        check("flush_run_ready", st_ready, 1);

        // Flush while empty still spends a cycle in FLUSH.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("eflush_ready", st_ready, 0);
        check("eflush_done0", flush_done, 0);
        tick();
        check("eflush_done", flush_done, 1);
        tick();
        check("eflush_done_off", flush_done, 0);
        ld_req = 1'b0;

        // Wrap: steady push+pop with one entry resident.
        ld_req = 1'b1;
        push_entry(32'h200, 32'hB00);
        ld_req = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            st_valid = 1'b1; st_addr = 32'h200 + 32'(4 * k); st_data = 32'hB00 + 32'(k); st_be = 4'hF;
            expect_write("wrap", 32'h200 + 32'(4 * (k - 1)), 32'hB00 + 32'(k - 1), 1);
        end
        st_valid = 1'b0;
        expect_write("wrap_last", 32'h228, 32'hB0A, 0);

        // Async reset mid-cycle with 3 entries pending.
        ld_req = 1'b1; ld_addr = 32'h100;
        push_entry(32'h300, 32'hE0);
        push_entry(32'h304, 32'hE1);
        push_entry(32'h308, 32'hE2);
        check("areset_cnt3", count, 3);
        ld_req = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("areset_count", count, 0);
        check("areset_ready", st_ready, 1);
        check("areset_we", dm_we, 0);
        check("areset_addr", dm_addr, 0);
        check("areset_data", dm_data, 0);
        check("areset_be", dm_be, 0);
        check("areset_pc", dm_pc, 0);
        check("areset_done", flush_done, 0);
        ld_req = 1'b1; ld_addr = 32'h0;
        #1 check("areset_stall", ld_stall, 0);
        tick();
        reset = 1'b0; ld_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_reset_we", dm_we, 0);
            check("post_reset_cnt", count, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
